// File: rtl/cpu_pkg.sv
// Shared encodings for the lab CPU: controller states, decoder opcode/op fields,
// register-select and writeback-select codes, and the packed control vector.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_WAIT   = 4'd0,
        S_DECODE = 4'd1,
        S_WIMM   = 4'd2,
        S_GETA   = 4'd3,
        S_GETB   = 4'd4,
        S_EXEC   = 4'd5,
        S_CMPS   = 4'd6,
        S_WRREG  = 4'd7,
        S_HALT   = 4'd8
    } state_e;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] MOV_IMM = 2'b10;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RM   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RN   = 3'b100;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic       loadc;
        logic       loads;
        logic       illegal;
    } ctrl_t;

    function automatic logic code_legal(input logic [4:0] code);
        case (code)
            {OPC_MOV, MOV_IMM}, {OPC_MOV, MOV_REG},
            {OPC_ALU, ALU_ADD}, {OPC_ALU, ALU_CMP},
            {OPC_ALU, ALU_AND}, {OPC_ALU, ALU_MVN}: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Decoder/top-level handshake and datapath control bundle for the CPU controller.
interface cpu_ctrl_fsm_if;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loadc;
    logic       loads;
    logic       illegal;

    modport master (
        output s, opcode, op,
        input  w, nsel, vsel, write, loada, loadb, asel, bsel, loadc, loads, illegal
    );

    modport slave (
        input  s, opcode, op,
        output w, nsel, vsel, write, loada, loadb, asel, bsel, loadc, loads, illegal
    );
endinterface

// File: rtl/cpu_ctrl_fsm_outdec.sv
// Moore output decode: maps the current state (and latched instruction code) to the
// datapath control vector. Unknown state encodings produce the idle WAIT vector.
module cpu_ctrl_outdec
    import cpu_pkg::*;
(
    input  state_e     state_i,
    input  logic [4:0] code_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_WAIT:   ctrl_o.w = 1'b1;
            S_DECODE: ctrl_o.illegal = ~code_legal(code_i);
            S_WIMM: begin
                ctrl_o.nsel  = NSEL_RN;
                ctrl_o.vsel  = VSEL_IMM;
                ctrl_o.write = 1'b1;
            end
            S_GETA: begin
                ctrl_o.nsel  = NSEL_RN;
                ctrl_o.loada = 1'b1;
            end
            S_GETB: begin
                ctrl_o.nsel  = NSEL_RM;
                ctrl_o.loadb = 1'b1;
            end
            S_EXEC: begin
                // Single-operand ops pass B through the ALU with A forced to zero
                ctrl_o.loadc = 1'b1;
                ctrl_o.asel  = (code_i == {OPC_MOV, MOV_REG}) ||
                               (code_i == {OPC_ALU, ALU_MVN});
            end
            S_CMPS:   ctrl_o.loads = 1'b1;
            S_WRREG: begin
                ctrl_o.nsel  = NSEL_RD;
                ctrl_o.vsel  = VSEL_C;
                ctrl_o.write = 1'b1;
            end
            S_HALT:   ctrl_o.illegal = 1'b1;
            default:  ctrl_o.w = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Moore sequencer for the lab CPU: latches the decoded instruction on start and
// steps the datapath through fetch-operand / execute / writeback one state per clock.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int STATE_W      = 4,
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input logic              clk,
    input logic              reset_n,
    cpu_ctrl_fsm_if.slave    bus
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [4:0]         code_q, code_d;
    state_e             cur;
    ctrl_t              ctrl;

    assign cur = state_e'(state_q[3:0]);

    always_comb begin
        state_d = STATE_W'(S_WAIT);
        code_d  = code_q;
        case (cur)
            S_WAIT: begin
                if (bus.s) begin
                    code_d  = {bus.opcode, bus.op};
                    state_d = STATE_W'(S_DECODE);
                end
            end
            S_DECODE: begin
                case (code_q)
                    {OPC_MOV, MOV_IMM}:                     state_d = STATE_W'(S_WIMM);
                    {OPC_MOV, MOV_REG}, {OPC_ALU, ALU_MVN}: state_d = STATE_W'(S_GETB);
                    {OPC_ALU, ALU_ADD}, {OPC_ALU, ALU_CMP},
                    {OPC_ALU, ALU_AND}:                     state_d = STATE_W'(S_GETA);
                    default: begin
                        if (ILLEGAL_TRAP) state_d = STATE_W'(S_HALT);
                    end
                endcase
            end
            S_GETA:  state_d = STATE_W'(S_GETB);
            S_GETB: begin
                if (code_q == {OPC_ALU, ALU_CMP}) state_d = STATE_W'(S_CMPS);
                else                              state_d = STATE_W'(S_EXEC);
            end
            S_EXEC:  state_d = STATE_W'(S_WRREG);
            S_HALT: begin
                if (ILLEGAL_TRAP) state_d = STATE_W'(S_HALT);
            end
            default: state_d = STATE_W'(S_WAIT);
        endcase
    end

    // The code latch needs no reset: it is only read after WAIT has loaded it
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= STATE_W'(S_WAIT);
        else          state_q <= state_d;
        code_q <= code_d;
    end

    cpu_ctrl_outdec u_outdec (
        .state_i (cur),
        .code_i  (code_q),
        .ctrl_o  (ctrl)
    );

    assign bus.w       = ctrl.w;
    assign bus.nsel    = ctrl.nsel;
    assign bus.vsel    = ctrl.vsel;
    assign bus.write   = ctrl.write;
    assign bus.loada   = ctrl.loada;
    assign bus.loadb   = ctrl.loadb;
    assign bus.asel    = ctrl.asel;
    assign bus.bsel    = ctrl.bsel;
    assign bus.loadc   = ctrl.loadc;
    assign bus.loads   = ctrl.loads;
    assign bus.illegal = ctrl.illegal;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: two instances (no trap / trap) see the same stimulus;
// the full control vector is compared against hand-written per-state constants.
module tb_cpu_ctrl_fsm;

    // Vector layout: {w, nsel[2:0], vsel[1:0], write, loada, loadb, asel, bsel, loadc, loads, illegal}
    localparam logic [13:0] E_WAIT  = 14'b1_000_00_00000000;
    localparam logic [13:0] E_DEC   = 14'b0_000_00_00000000;
    localparam logic [13:0] E_DECI  = 14'b0_000_00_00000001;
    localparam logic [13:0] E_WIMM  = 14'b0_100_10_10000000;
    localparam logic [13:0] E_GETA  = 14'b0_100_00_01000000;
    localparam logic [13:0] E_GETB  = 14'b0_001_00_00100000;
    localparam logic [13:0] E_EXEC0 = 14'b0_000_00_00000100;
    localparam logic [13:0] E_EXEC1 = 14'b0_000_00_00010100;
    localparam logic [13:0] E_CMPS  = 14'b0_000_00_00000010;
    localparam logic [13:0] E_WRREG = 14'b0_010_00_10000000;
    localparam logic [13:0] E_HALT  = 14'b0_000_00_00000001;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;
    logic [13:0] exp_seq [0:4];

    cpu_ctrl_fsm_if bus0 ();
    cpu_ctrl_fsm_if bus1 ();

    cpu_ctrl_fsm #(.STATE_W(4), .ILLEGAL_TRAP(1'b0)) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    cpu_ctrl_fsm #(.STATE_W(4), .ILLEGAL_TRAP(1'b1)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    logic [13:0] v0, v1;
    assign v0 = {bus0.w, bus0.nsel, bus0.vsel, bus0.write, bus0.loada, bus0.loadb,
                 bus0.asel, bus0.bsel, bus0.loadc, bus0.loads, bus0.illegal};
    assign v1 = {bus1.w, bus1.nsel, bus1.vsel, bus1.write, bus1.loada, bus1.loadb,
                 bus1.asel, bus1.bsel, bus1.loadc, bus1.loads, bus1.illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [2:0] opc, input logic [1:0] op);
        bus0.s = s; bus0.opcode = opc; bus0.op = op;
        bus1.s = s; bus1.opcode = opc; bus1.op = op;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_seq(input logic [13:0] a, input logic [13:0] b, input logic [13:0] c,
                           input logic [13:0] d, input logic [13:0] e);
        exp_seq[0] = a; exp_seq[1] = b; exp_seq[2] = c; exp_seq[3] = d; exp_seq[4] = e;
    endtask

    // Accept one instruction, scramble the decoder inputs, then walk the expected states
    task automatic run(input string tag, input logic [2:0] opc, input logic [1:0] op, input int n);
        drive(1'b1, opc, op);
        step();
        drive(1'b0, 3'b111, 2'b11);
        for (int k = 0; k < n; k++) begin
            check_eq($sformatf("%s_c%0d", tag, k), v0, exp_seq[k]);
            check_eq($sformatf("%s_c%0d_trap", tag, k), v1, exp_seq[k]);
            step();
        end
        check_eq({tag, "_done"}, v0, E_WAIT);
        check_eq({tag, "_done_trap"}, v1, E_WAIT);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        drive(1'b1, 3'b110, 2'b10);
        step();
        step();
        check_eq("reset", v0, E_WAIT);
        check_eq("reset_trap", v1, E_WAIT);
        drive(1'b0, 3'b000, 2'b00);
        reset_n = 1'b1;
        step();
        check_eq("idle", v0, E_WAIT);

        set_seq(E_DEC, E_WIMM, E_WAIT, E_WAIT, E_WAIT);
        run("movimm", 3'b110, 2'b10, 2);

        set_seq(E_DEC, E_GETA, E_GETB, E_EXEC0, E_WRREG);
        run("add", 3'b101, 2'b00, 5);

        set_seq(E_DEC, E_GETA, E_GETB, E_CMPS, E_WAIT);
        run("cmp", 3'b101, 2'b01, 4);

        set_seq(E_DEC, E_GETA, E_GETB, E_EXEC0, E_WRREG);
        run("and", 3'b101, 2'b10, 5);

        set_seq(E_DEC, E_GETB, E_EXEC1, E_WRREG, E_WAIT);
        run("movreg", 3'b110, 2'b00, 4);

        // s held high: second accept on the edge right after the single WAIT cycle
        drive(1'b1, 3'b110, 2'b10);
        step(); check_eq("b2b_dec1", v0, E_DEC);
        step(); check_eq("b2b_wimm1", v0, E_WIMM);
        step(); check_eq("b2b_wait", v0, E_WAIT);
        step(); check_eq("b2b_dec2", v0, E_DEC);
        drive(1'b0, 3'b000, 2'b00);
        step(); check_eq("b2b_wimm2", v0, E_WIMM);
        step(); check_eq("b2b_done", v0, E_WAIT);

        // Reset in GETB of an ADD aborts before any write
        drive(1'b1, 3'b101, 2'b00);
        step();
        drive(1'b0, 3'b000, 2'b00);
        check_eq("rstmid_dec", v0, E_DEC);
        step(); check_eq("rstmid_geta", v0, E_GETA);
        step(); check_eq("rstmid_getb", v0, E_GETB);
        reset_n = 1'b0;
        step(); check_eq("rstmid_wait", v0, E_WAIT);
        reset_n = 1'b1;
        step(); check_eq("rstmid_idle", v0, E_WAIT);

        set_seq(E_DEC, E_GETB, E_EXEC1, E_WRREG, E_WAIT);
        run("mvn", 3'b101, 2'b11, 4);

        // Illegal code: plain instance returns to WAIT, trap instance halts until reset
        drive(1'b1, 3'b111, 2'b00);
        step();
        drive(1'b0, 3'b000, 2'b00);
        check_eq("ill_dec", v0, E_DECI);
        check_eq("ill_dec_trap", v1, E_DECI);
        step();
        check_eq("ill_wait", v0, E_WAIT);
        check_eq("ill_halt", v1, E_HALT);
        drive(1'b1, 3'b110, 2'b10);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq($sformatf("ill_halt_hold%0d", k), v1, E_HALT);
        end
        drive(1'b0, 3'b000, 2'b00);
        reset_n = 1'b0;
        step();
        check_eq("ill_rst", v0, E_WAIT);
        check_eq("ill_rst_trap", v1, E_WAIT);
        reset_n = 1'b1;

        set_seq(E_DEC, E_WIMM, E_WAIT, E_WAIT, E_WAIT);
        run("post_halt", 3'b110, 2'b10, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
